// File: rtl/hazard_pkg.sv
// Shared types and output presets for the pipeline hazard sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_pkg;

    // Sequencer states; encoding is visible on the debug port.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        FLUSH     = 2'd2,
        IMEM_WAIT = 2'd3
    } hz_state_t;

    // Register x0 is hard-wired to zero and can never create a RAW hazard.
    localparam int X0 = '0;

    // Bundle of the five pipeline control strobes driven each cycle.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_flush;
    } hz_ctl_t;

    // Normal flow: everything advances, nothing is squashed.
    function automatic hz_ctl_t ctl_run();
        hz_ctl_t c;
        c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
              idex_bubble: 1'b0, exmem_flush: 1'b0};
        return c;
    endfunction

    // Reset: freeze the PC and squash every younger stage.
    function automatic hz_ctl_t ctl_reset();
        hz_ctl_t c;
        c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
              idex_bubble: 1'b1, exmem_flush: 1'b1};
        return c;
    endfunction

    // Taken branch / flush window: PC loads the target (when fetch allows),
    // the three wrong-path instructions are squashed.
    function automatic hz_ctl_t ctl_flush(input logic pc_en);
        hz_ctl_t c;
        c = '{pc_write: pc_en, ifid_write: 1'b0, ifid_flush: 1'b1,
              idex_bubble: 1'b1, exmem_flush: 1'b1};
        return c;
    endfunction

    // Load-use: hold PC and ID, inject a bubble into EX.
    function automatic hz_ctl_t ctl_load_use();
        hz_ctl_t c;
        c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
              idex_bubble: 1'b1, exmem_flush: 1'b0};
        return c;
    endfunction

    // Fetch wait: hold PC, feed a NOP into ID, let older stages drain.
    function automatic hz_ctl_t ctl_imem_wait();
        hz_ctl_t c;
        c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
              idex_bubble: 1'b0, exmem_flush: 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Latency: q updates one cycle after inc is sampled high.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic         w_at_max;

    assign w_at_max = &r_q;

    // Count qualified events; stick at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (inc && !w_at_max) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer for the 5-stage core: load-use, taken-branch and fetch-wait handling.
// Latency: control strobes are combinational from state + inputs; state/counters/err registered.
// Backpressure: stalls PC and IF/ID on load-use or imem wait; branch flush overrides everything but reset.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int LU_CYCLES = 1,
    parameter int FLUSH_CYC = 1,
    parameter int WAIT_MAX  = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout,
    output logic [1:0]       state_o
);

    // Counter widths sized to hold their load / saturation values.
    localparam int LU_W = $clog2(LU_CYCLES + 1);
    localparam int FL_W = $clog2(FLUSH_CYC + 1);
    localparam int WT_W = $clog2(WAIT_MAX + 1);

    hz_state_t   r_state;
    hz_state_t   w_state_nxt;
    logic [LU_W-1:0] r_lu_cnt;
    logic [LU_W-1:0] w_lu_cnt_nxt;
    logic [FL_W-1:0] r_fl_cnt;
    logic [FL_W-1:0] w_fl_cnt_nxt;
    logic [WT_W-1:0] r_wait_cnt;
    logic [WT_W-1:0] w_wait_cnt_nxt;
    logic        r_err;
    logic        w_err_nxt;

    hz_ctl_t     w_ctl;
    logic        w_lu_haz;
    logic        w_rs1_match;
    logic        w_rs2_match;
    logic        w_stall_inc;

    // RAW on a load result: EX load targets a register that ID reads (x0 excluded).
    assign w_rs1_match = (ex_rd == id_rs1);
    assign w_rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
    assign w_lu_haz    = ex_mem_read && (ex_rd != REG_W'(X0)) && (w_rs1_match || w_rs2_match);

    // Next-state and control strobes; branch outranks every non-reset condition.
    always_comb begin
        w_ctl          = ctl_run();
        w_state_nxt    = r_state;
        w_lu_cnt_nxt   = r_lu_cnt;
        w_fl_cnt_nxt   = r_fl_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_nxt      = r_err;

        if (reset) begin
            w_ctl          = ctl_reset();
            w_state_nxt    = RUN;
            w_lu_cnt_nxt   = '0;
            w_fl_cnt_nxt   = '0;
            w_wait_cnt_nxt = '0;
            w_err_nxt      = 1'b0;
        end else if (branch_taken) begin
            // PC takes the target now; any pending load-use or fetch wait is moot.
            w_ctl          = ctl_flush(1'b1);
            w_lu_cnt_nxt   = '0;
            w_wait_cnt_nxt = '0;
            if (FLUSH_CYC > 1) begin
                w_state_nxt  = FLUSH;
                w_fl_cnt_nxt = FL_W'(FLUSH_CYC - 1);
            end else begin
                w_state_nxt  = RUN;
                w_fl_cnt_nxt = '0;
            end
        end else if (r_state == FLUSH) begin
            // Keep squashing; PC only advances once fetch data is there.
            w_ctl = ctl_flush(imem_ready);
            if (r_fl_cnt <= FL_W'(1)) begin
                w_state_nxt  = RUN;
                w_fl_cnt_nxt = '0;
            end else begin
                w_fl_cnt_nxt = r_fl_cnt - FL_W'(1);
            end
        end else if (r_state == LU_STALL) begin
            // Committed to the full stall length; the hazard is not re-checked.
            w_ctl = ctl_load_use();
            if (r_lu_cnt <= LU_W'(1)) begin
                w_state_nxt  = RUN;
                w_lu_cnt_nxt = '0;
            end else begin
                w_lu_cnt_nxt = r_lu_cnt - LU_W'(1);
            end
        end else if (w_lu_haz) begin
            // Load-use wins over fetch wait so the ID instruction is held, not lost.
            w_ctl          = ctl_load_use();
            w_wait_cnt_nxt = '0;
            if (LU_CYCLES > 1) begin
                w_state_nxt  = LU_STALL;
                w_lu_cnt_nxt = LU_W'(LU_CYCLES - 1);
            end else begin
                w_state_nxt  = RUN;
                w_lu_cnt_nxt = '0;
            end
        end else if (!imem_ready) begin
            w_ctl       = ctl_imem_wait();
            w_state_nxt = IMEM_WAIT;
            if (r_state == IMEM_WAIT) begin
                // Waiting past the limit flags a timeout; the count parks at the limit.
                if (r_wait_cnt == WT_W'(WAIT_MAX)) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WT_W'(1);
                end
            end else begin
                w_wait_cnt_nxt = WT_W'(1);
            end
        end else begin
            // Fetch data present (fresh or after a wait): resume normal flow.
            w_ctl          = ctl_run();
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
        end
    end

    // State, sub-counters and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_lu_cnt   <= '0;
            r_fl_cnt   <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lu_cnt   <= w_lu_cnt_nxt;
            r_fl_cnt   <= w_fl_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // A stall cycle is any non-reset cycle where the PC does not load.
    assign w_stall_inc = !reset && !w_ctl.pc_write;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_taken),
        .q     (flush_cnt)
    );

    assign pc_write    = w_ctl.pc_write;
    assign ifid_write  = w_ctl.ifid_write;
    assign ifid_flush  = w_ctl.ifid_flush;
    assign idex_bubble = w_ctl.idex_bubble;
    assign exmem_flush = w_ctl.exmem_flush;
    assign err_timeout = r_err;
    assign state_o     = r_state;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: vector table on a single-cycle-stall instance, sequences on a multi-cycle instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_ctrl_unit;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       branch_taken;
    logic       imem_ready;

    // Instance A: LU_CYCLES=1, FLUSH_CYC=1, WAIT_MAX=3
    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_exmem_flush;
    logic [31:0] a_stall_cnt, a_flush_cnt;
    logic        a_err;
    logic [1:0]  a_state;

    // Instance B: LU_CYCLES=3, FLUSH_CYC=2, WAIT_MAX=64, 4-bit counters
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_exmem_flush;
    logic [3:0]  b_stall_cnt, b_flush_cnt;
    logic        b_err;
    logic [1:0]  b_state;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl_unit #(
        .REG_W(5), .LU_CYCLES(1), .FLUSH_CYC(1), .WAIT_MAX(3), .CNT_W(32)
    ) dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .imem_ready(imem_ready),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_bubble(a_idex_bubble), .exmem_flush(a_exmem_flush),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt),
        .err_timeout(a_err), .state_o(a_state)
    );

    hazard_ctrl_unit #(
        .REG_W(5), .LU_CYCLES(3), .FLUSH_CYC(2), .WAIT_MAX(64), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .imem_ready(imem_ready),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .exmem_flush(b_exmem_flush),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt),
        .err_timeout(b_err), .state_o(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector ordering: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}
    localparam logic [4:0] C_RUN  = 5'b11000;
    localparam logic [4:0] C_LU   = 5'b00010;
    localparam logic [4:0] C_BR   = 5'b10111;
    localparam logic [4:0] C_WAIT = 5'b00100;
    localparam logic [4:0] C_RST  = 5'b00111;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u;
        logic       bt;
        logic       ir;
        logic [4:0] ctl;
        logic [1:0] st;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic rst, input logic mr, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic u,
                                input logic bt, input logic ir, input logic [4:0] ctl,
                                input logic [1:0] st);
        vec_t v;
        v = '{rst: rst, mr: mr, rd: rd, rs1: rs1, rs2: rs2, u: u, bt: bt, ir: ir, ctl: ctl, st: st};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u, input logic bt, input logic ir);
        ex_mem_read  = mr;
        ex_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs2  = u;
        branch_taken = bt;
        imem_ready   = ir;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        idle();
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    function automatic logic [4:0] ctl_a();
        return {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_exmem_flush};
    endfunction

    function automatic logic [4:0] ctl_b();
        return {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_exmem_flush};
    endfunction

    initial begin
        reset = 1'b1;
        idle();

        //            rst   mr    rd     rs1    rs2    u     bt    ir    ctl     next state
        vecs[0]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_RUN,  2'd0);
        vecs[1]  = mk(1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, C_LU,   2'd0);
        vecs[2]  = mk(1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b1, C_RUN,  2'd0);
        vecs[3]  = mk(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, C_LU,   2'd0);
        vecs[4]  = mk(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, C_RUN,  2'd0);
        vecs[5]  = mk(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, C_RUN,  2'd0);
        vecs[6]  = mk(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, C_BR,   2'd0);
        vecs[7]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_WAIT, 2'd3);
        vecs[8]  = mk(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, C_LU,   2'd0);
        vecs[9]  = mk(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_BR,   2'd0);
        vecs[10] = mk(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, C_RST,  2'd0);
        vecs[11] = mk(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, C_LU,   2'd0);

        // Reset state
        do_reset(2);
        @(negedge clk);
        chk("rst_state", {30'd0, a_state}, 32'd0);
        chk("rst_stall", a_stall_cnt, 32'd0);
        chk("rst_flush", a_flush_cnt, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_ctl_idle", {27'd0, ctl_a()}, {27'd0, C_RUN});

        // Single-cycle vectors from RUN on instance A
        for (int i = 0; i < 12; i++) begin
            reset = 1'b1;
            tick();
            reset = vecs[i].rst;
            set_in(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].u, vecs[i].bt, vecs[i].ir);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), {27'd0, ctl_a()}, {27'd0, vecs[i].ctl});
            tick();
            chk($sformatf("vec%0d_state", i), {30'd0, a_state}, {30'd0, vecs[i].st});
            idle();
        end

        // Reset held 3 cycles in the middle of a load-use stall (instance B)
        do_reset(2);
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t1_in_lu", {30'd0, b_state}, 32'd1);
        idle();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t1_rst_flush", {31'd0, b_ifid_flush}, 32'd1);
            chk("t1_rst_write", {31'd0, b_ifid_write}, 32'd0);
            tick();
        end
        reset = 1'b0;
        chk("t1_state", {30'd0, b_state}, 32'd0);
        @(negedge clk);
        chk("t1_ctl_run", {27'd0, ctl_b()}, {27'd0, C_RUN});
        chk("t1_stall", {28'd0, b_stall_cnt}, 32'd0);
        chk("t1_flushc", {28'd0, b_flush_cnt}, 32'd0);

        // rs2 load-use stalls once; same with rs2 unused does not
        do_reset(2);
        set_in(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_no_stall_ctl", {27'd0, ctl_a()}, {27'd0, C_RUN});
        tick();
        idle();
        chk("t2_stall", a_stall_cnt, 32'd1);

        // Branch coincident with load-use
        do_reset(2);
        set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t4_ctl", {27'd0, ctl_a()}, {27'd0, C_BR});
        tick();
        idle();
        chk("t4_flushc", a_flush_cnt, 32'd1);
        chk("t4_stall", a_stall_cnt, 32'd0);

        // Fetch wait of 4 cycles against WAIT_MAX=3
        do_reset(2);
        imem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_ifid_flush", {31'd0, a_ifid_flush}, 32'd1);
            chk("t5_pc_write", {31'd0, a_pc_write}, 32'd0);
            if (c == 3) chk("t5_err_pre", {31'd0, a_err}, 32'd0);
            tick();
        end
        chk("t5_stall", a_stall_cnt, 32'd4);
        chk("t5_err", {31'd0, a_err}, 32'd1);
        chk("t5_state_wait", {30'd0, a_state}, 32'd3);
        imem_ready = 1'b1;
        @(negedge clk);
        chk("t5_resume_ctl", {27'd0, ctl_a()}, {27'd0, C_RUN});
        tick();
        chk("t5_state_run", {30'd0, a_state}, 32'd0);
        tick();
        chk("t5_err_sticky", {31'd0, a_err}, 32'd1);
        chk("t5_stall_hold", a_stall_cnt, 32'd4);

        // 4-bit stall counter saturates instead of wrapping (instance B)
        do_reset(2);
        imem_ready = 1'b0;
        repeat (20) tick();
        chk("sat_stall", {28'd0, b_stall_cnt}, 32'd15);
        chk("sat_no_err", {31'd0, b_err}, 32'd0);
        idle();
        tick();

        // LU_CYCLES=3: three stall cycles, hazard dropped after the first
        do_reset(2);
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_lu_c1", {27'd0, ctl_b()}, {27'd0, C_LU});
        tick();
        chk("t6_state_c1", {30'd0, b_state}, 32'd1);
        idle();
        @(negedge clk);
        chk("t6_lu_c2", {27'd0, ctl_b()}, {27'd0, C_LU});
        tick();
        chk("t6_state_c2", {30'd0, b_state}, 32'd1);
        @(negedge clk);
        chk("t6_lu_c3", {27'd0, ctl_b()}, {27'd0, C_LU});
        tick();
        chk("t6_state_c3", {30'd0, b_state}, 32'd0);
        chk("t6_stall", {28'd0, b_stall_cnt}, 32'd3);
        @(negedge clk);
        chk("t6_run", {27'd0, ctl_b()}, {27'd0, C_RUN});

        // FLUSH_CYC=2: branch during stall cycle 2 gives exactly 2 flush cycles
        do_reset(2);
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t6b_fl_c1", {27'd0, ctl_b()}, {27'd0, C_BR});
        tick();
        chk("t6b_state_fl", {30'd0, b_state}, 32'd2);
        idle();
        @(negedge clk);
        chk("t6b_fl_c2", {27'd0, ctl_b()}, {27'd0, C_BR});
        tick();
        chk("t6b_state_run", {30'd0, b_state}, 32'd0);
        @(negedge clk);
        chk("t6b_run", {27'd0, ctl_b()}, {27'd0, C_RUN});
        chk("t6b_flushc", {28'd0, b_flush_cnt}, 32'd1);
        chk("t6b_stall", {28'd0, b_stall_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
